// File: rtl/serv_bus_mem.sv
// rtl/serv_bus_mem.sv - single-port word memory shared by SERV ibus, dbus and a host Wishbone port
//
// Purpose:
//   One 2**AW x 32-bit array serialised by a fixed-priority arbiter
//   (host > dbus > ibus) and a two-state IDLE/RESP FSM. The array access
//   happens on the grant edge and the winner is acked in the next cycle,
//   so there is at most one access every two cycles.
//
// Configuration:
//   SERV_BUS_MEM_HOST_EN - when defined the host Wishbone port is live;
//   when undefined the wbs_* inputs are ignored, wbs_ack_o/wbs_dat_o stay 0
//   and arbitration is dbus > ibus only.
//
// Ports:
//   clk, i_rst                        clock, asynchronous active-high reset
//   i_ibus_adr/cyc, o_ibus_rdt/ack    instruction fetch (read-only)
//   i_dbus_adr/dat/sel/we/cyc         data access request (byte lanes)
//   o_dbus_rdt/ack                    data response
//   wbs_cyc_i/stb_i/we_i/adr_i/dat_i/sel_i   host Wishbone request
//   wbs_dat_o/ack_o                   host Wishbone response

module serv_bus_mem #(
  parameter int          AW        = 8,
  parameter logic [31:0] HOST_BASE = 32'h3000_0000
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o
);

  typedef enum logic {S_IDLE, S_RESP} state_e;
  typedef enum logic [1:0] {G_IBUS, G_DBUS, G_HOST} gnt_e;

  logic [31:0] mem [2**AW];

  state_e      state_q, state_d;
  gnt_e        gnt_q, gnt_d;
  logic [31:0] ibus_rdt_q, ibus_rdt_d;
  logic [31:0] dbus_rdt_q, dbus_rdt_d;
  logic [31:0] host_rdt_q, host_rdt_d;

  logic          host_req;
  logic          ibus_in_range, dbus_in_range;
  logic          acc_valid, acc_we;
  logic [AW-1:0] acc_idx;
  logic [31:0]   acc_dat, rd_word, wr_word;
  logic [3:0]    acc_sel;
  logic          mem_we;
  logic          unused_ok;

`ifdef SERV_BUS_MEM_HOST_EN
  assign host_req  = wbs_cyc_i & wbs_stb_i &
                     (wbs_adr_i[31:AW+2] == HOST_BASE[31:AW+2]);
  assign unused_ok = &{1'b0, wbs_adr_i[1:0], i_ibus_adr[1:0], i_dbus_adr[1:0]};
`else
  assign host_req  = 1'b0;
  assign unused_ok = &{1'b0, wbs_cyc_i, wbs_stb_i, wbs_adr_i[31:AW+2],
                       wbs_adr_i[1:0], i_ibus_adr[1:0], i_dbus_adr[1:0]};
`endif

  // Core buses only decode the low AW+2 bits; anything above is acked with zero data.
  assign ibus_in_range = (i_ibus_adr[31:AW+2] == '0);
  assign dbus_in_range = (i_dbus_adr[31:AW+2] == '0);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    ibus_rdt_d = ibus_rdt_q;
    dbus_rdt_d = dbus_rdt_q;
    host_rdt_d = host_rdt_q;
    acc_valid  = 1'b0;
    acc_we     = 1'b0;
    acc_idx    = '0;
    acc_dat    = '0;
    acc_sel    = '0;
    rd_word    = '0;
    wr_word    = '0;

    case (state_q)
      S_IDLE: begin
        if (host_req) begin
          state_d   = S_RESP;
          gnt_d     = G_HOST;
          acc_valid = 1'b1;
          acc_we    = wbs_we_i;
          acc_idx   = wbs_adr_i[AW+1:2];
          acc_dat   = wbs_dat_i;
          acc_sel   = wbs_sel_i;
        end else if (i_dbus_cyc) begin
          state_d   = S_RESP;
          gnt_d     = G_DBUS;
          acc_valid = dbus_in_range;
          acc_we    = i_dbus_we;
          acc_idx   = i_dbus_adr[AW+1:2];
          acc_dat   = i_dbus_dat;
          acc_sel   = i_dbus_sel;
        end else if (i_ibus_cyc) begin
          state_d   = S_RESP;
          gnt_d     = G_IBUS;
          acc_valid = ibus_in_range;
          acc_idx   = i_ibus_adr[AW+1:2];
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Read-before-write: the response carries the word as it was before this edge.
    if (acc_valid) begin
      rd_word = mem[acc_idx];
    end
    for (int b = 0; b < 4; b++) begin
      wr_word[8*b +: 8] = acc_sel[b] ? acc_dat[8*b +: 8] : rd_word[8*b +: 8];
    end

    if (state_q == S_IDLE && state_d == S_RESP) begin
      case (gnt_d)
        G_HOST:  host_rdt_d = rd_word;
        G_DBUS:  dbus_rdt_d = rd_word;
        default: ibus_rdt_d = rd_word;
      endcase
    end
  end

  // The array is not reset; suppress writes while reset is held so only
  // accesses granted before reset land in memory.
  assign mem_we = acc_valid & acc_we & ~i_rst;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[acc_idx] <= wr_word;
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= G_IBUS;
      ibus_rdt_q <= '0;
      dbus_rdt_q <= '0;
      host_rdt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ibus_rdt_q <= ibus_rdt_d;
      dbus_rdt_q <= dbus_rdt_d;
      host_rdt_q <= host_rdt_d;
    end
  end

  assign o_ibus_ack = (state_q == S_RESP) && (gnt_q == G_IBUS);
  assign o_dbus_ack = (state_q == S_RESP) && (gnt_q == G_DBUS);
  assign wbs_ack_o  = (state_q == S_RESP) && (gnt_q == G_HOST);
  assign o_ibus_rdt = ibus_rdt_q;
  assign o_dbus_rdt = dbus_rdt_q;
  // host_rdt_q is never loaded without the host port, so this stays 0 then.
  assign wbs_dat_o  = host_rdt_q;

endmodule

// File: tb/tb_serv_bus_mem.sv
// tb/tb_serv_bus_mem.sv - directed self-checking bench for serv_bus_mem

module tb_serv_bus_mem;

  logic        clk;
  logic        i_rst;
  logic [31:0] i_ibus_adr;
  logic        i_ibus_cyc;
  logic [31:0] o_ibus_rdt;
  logic        o_ibus_ack;
  logic [31:0] i_dbus_adr;
  logic [31:0] i_dbus_dat;
  logic [3:0]  i_dbus_sel;
  logic        i_dbus_we;
  logic        i_dbus_cyc;
  logic [31:0] o_dbus_rdt;
  logic        o_dbus_ack;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;

  int tests;
  int fails;

  serv_bus_mem dut (
    .clk(clk), .i_rst(i_rst),
    .i_ibus_adr(i_ibus_adr), .i_ibus_cyc(i_ibus_cyc),
    .o_ibus_rdt(o_ibus_rdt), .o_ibus_ack(o_ibus_ack),
    .i_dbus_adr(i_dbus_adr), .i_dbus_dat(i_dbus_dat), .i_dbus_sel(i_dbus_sel),
    .i_dbus_we(i_dbus_we), .i_dbus_cyc(i_dbus_cyc),
    .o_dbus_rdt(o_dbus_rdt), .o_dbus_ack(o_dbus_ack),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // lat = negedges from request to ack (1 = next cycle), 0 = no ack within 10 cycles.
  task automatic dbus_xfer(input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic we,
                           output logic [31:0] rdt, output int lat);
    @(negedge clk);
    i_dbus_adr = adr; i_dbus_dat = dat; i_dbus_sel = sel; i_dbus_we = we; i_dbus_cyc = 1'b1;
    lat = 0; rdt = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (o_dbus_ack) begin lat = k; rdt = o_dbus_rdt; break; end
    end
    i_dbus_cyc = 1'b0; i_dbus_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic ibus_xfer(input logic [31:0] adr, output logic [31:0] rdt, output int lat);
    @(negedge clk);
    i_ibus_adr = adr; i_ibus_cyc = 1'b1;
    lat = 0; rdt = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (o_ibus_ack) begin lat = k; rdt = o_ibus_rdt; break; end
    end
    i_ibus_cyc = 1'b0;
    @(negedge clk);
  endtask

  task automatic host_xfer(input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic we,
                           output logic [31:0] rdt, output int lat);
    @(negedge clk);
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel; wbs_we_i = we;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    lat = 0; rdt = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (wbs_ack_o) begin lat = k; rdt = wbs_dat_o; break; end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (o_ibus_ack !== 1'b0) begin fails++; $display("FAIL reset_ibus_ack got %b exp 0", o_ibus_ack); end
    tests++; if (o_dbus_ack !== 1'b0) begin fails++; $display("FAIL reset_dbus_ack got %b exp 0", o_dbus_ack); end
    tests++; if (wbs_ack_o !== 1'b0) begin fails++; $display("FAIL reset_wbs_ack got %b exp 0", wbs_ack_o); end
    tests++; if (o_ibus_rdt !== 32'h0) begin fails++; $display("FAIL reset_ibus_rdt got %h exp 0", o_ibus_rdt); end
    tests++; if (o_dbus_rdt !== 32'h0) begin fails++; $display("FAIL reset_dbus_rdt got %h exp 0", o_dbus_rdt); end
    tests++; if (wbs_dat_o !== 32'h0) begin fails++; $display("FAIL reset_wbs_dat got %h exp 0", wbs_dat_o); end
    i_rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ibus_fetch;
    logic [31:0] rdt; int lat;
    dbus_xfer(32'h0, 32'hCAFE_F00D, 4'hF, 1'b1, rdt, lat);
    tests++; if (lat != 1) begin fails++; $display("FAIL preload_lat got %0d exp 1", lat); end
    ibus_xfer(32'h0, rdt, lat);
    tests++; if (lat != 1) begin fails++; $display("FAIL fetch_lat got %0d exp 1", lat); end
    tests++; if (rdt !== 32'hCAFE_F00D) begin fails++; $display("FAIL fetch_rdt got %h exp cafef00d", rdt); end
  endtask

  task automatic test_host;
    logic [31:0] rdt; int lat;
`ifdef SERV_BUS_MEM_HOST_EN
    host_xfer(32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, rdt, lat);
    tests++; if (lat != 1) begin fails++; $display("FAIL host_wr_lat got %0d exp 1", lat); end
    host_xfer(32'h3000_0010, 32'h0, 4'h0, 1'b0, rdt, lat);
    tests++; if (rdt !== 32'hDEAD_BEEF) begin fails++; $display("FAIL host_rd got %h exp deadbeef", rdt); end
    // host beats dbus when both request in the same cycle
    @(negedge clk);
    wbs_adr_i = 32'h3000_0000; wbs_we_i = 1'b0; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    i_dbus_adr = 32'h10; i_dbus_we = 1'b0; i_dbus_cyc = 1'b1;
    @(negedge clk);
    tests++; if (wbs_ack_o !== 1'b1 || o_dbus_ack !== 1'b0) begin
      fails++; $display("FAIL host_prio got host=%b dbus=%b exp 1/0", wbs_ack_o, o_dbus_ack); end
    tests++; if (wbs_dat_o !== 32'hCAFE_F00D) begin fails++; $display("FAIL host_prio_rdt got %h exp cafef00d", wbs_dat_o); end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(negedge clk); @(negedge clk);
    tests++; if (o_dbus_ack !== 1'b1) begin fails++; $display("FAIL host_prio_dbus got %b exp 1", o_dbus_ack); end
    i_dbus_cyc = 1'b0;
    @(negedge clk);
`else
    host_xfer(32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, rdt, lat);
    tests++; if (lat != 0) begin fails++; $display("FAIL host_disabled_ack got lat %0d exp none", lat); end
    tests++; if (wbs_dat_o !== 32'h0) begin fails++; $display("FAIL host_disabled_dat got %h exp 0", wbs_dat_o); end
    dbus_xfer(32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1, rdt, lat);
`endif
    dbus_xfer(32'h10, 32'h0, 4'h0, 1'b0, rdt, lat);
    tests++; if (rdt !== 32'hDEAD_BEEF) begin fails++; $display("FAIL dbus_rd_0x10 got %h exp deadbeef", rdt); end
  endtask

  task automatic test_byte_lanes;
    logic [31:0] rdt; int lat;
    dbus_xfer(32'h20, 32'hFFFF_FFFF, 4'hF, 1'b1, rdt, lat);
    dbus_xfer(32'h20, 32'h1122_3344, 4'b0101, 1'b1, rdt, lat);
    tests++; if (rdt !== 32'hFFFF_FFFF) begin fails++; $display("FAIL rbw_rdt got %h exp ffffffff", rdt); end
    dbus_xfer(32'h20, 32'h0, 4'h0, 1'b0, rdt, lat);
    tests++; if (rdt !== 32'hFF22_FF44) begin fails++; $display("FAIL lanes got %h exp ff22ff44", rdt); end
    dbus_xfer(32'h20, 32'h0, 4'h0, 1'b1, rdt, lat);
    tests++; if (lat != 1) begin fails++; $display("FAIL sel0_ack got lat %0d exp 1", lat); end
    dbus_xfer(32'h23, 32'h0, 4'h0, 1'b0, rdt, lat);
    tests++; if (rdt !== 32'hFF22_FF44) begin fails++; $display("FAIL sel0_nowrite got %h exp ff22ff44", rdt); end
  endtask

  task automatic test_arbitration;
    int dk, ik;
    logic [31:0] drdt, irdt;
    dk = 0; ik = 0; drdt = '0; irdt = '0;
    @(negedge clk);
    i_ibus_adr = 32'h0; i_ibus_cyc = 1'b1;
    i_dbus_adr = 32'h20; i_dbus_we = 1'b0; i_dbus_cyc = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (o_ibus_ack && o_dbus_ack) begin
        tests++; fails++; $display("FAIL arb_both_acked cycle %0d", k);
      end
      if (k == 1) begin
        tests++; if (o_ibus_rdt !== 32'hCAFE_F00D) begin fails++; $display("FAIL arb_ibus_hold got %h exp cafef00d", o_ibus_rdt); end
      end
      if (o_dbus_ack && dk == 0) begin dk = k; drdt = o_dbus_rdt; i_dbus_cyc = 1'b0; end
      if (o_ibus_ack && ik == 0) begin ik = k; irdt = o_ibus_rdt; i_ibus_cyc = 1'b0; end
    end
    i_ibus_cyc = 1'b0; i_dbus_cyc = 1'b0;
    tests++; if (dk != 1) begin fails++; $display("FAIL arb_dbus_cycle got %0d exp 1", dk); end
    tests++; if (ik != 3) begin fails++; $display("FAIL arb_ibus_cycle got %0d exp 3", ik); end
    tests++; if (drdt !== 32'hFF22_FF44) begin fails++; $display("FAIL arb_dbus_rdt got %h exp ff22ff44", drdt); end
    tests++; if (irdt !== 32'hCAFE_F00D) begin fails++; $display("FAIL arb_ibus_rdt got %h exp cafef00d", irdt); end
  endtask

  task automatic test_out_of_range;
    logic [31:0] rdt; int lat;
    dbus_xfer(32'h0001_0000, 32'h0, 4'h0, 1'b0, rdt, lat);
    tests++; if (lat != 1) begin fails++; $display("FAIL oor_ack got lat %0d exp 1", lat); end
    tests++; if (rdt !== 32'h0) begin fails++; $display("FAIL oor_rdt got %h exp 0", rdt); end
    dbus_xfer(32'h0001_0020, 32'h0, 4'hF, 1'b1, rdt, lat);
    dbus_xfer(32'h20, 32'h0, 4'h0, 1'b0, rdt, lat);
    tests++; if (rdt !== 32'hFF22_FF44) begin fails++; $display("FAIL oor_no_alias got %h exp ff22ff44", rdt); end
    host_xfer(32'h3100_0000, 32'h1234_5678, 4'hF, 1'b1, rdt, lat);
    tests++; if (lat != 0) begin fails++; $display("FAIL host_outside_ack got lat %0d exp none", lat); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rdt; int lat; bit seen;
    seen = 1'b0;
    @(negedge clk);
    i_dbus_adr = 32'h10; i_dbus_dat = 32'h55AA_55AA; i_dbus_sel = 4'hF; i_dbus_we = 1'b1; i_dbus_cyc = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (o_dbus_ack) begin seen = 1'b1; break; end
    end
    tests++; if (!seen) begin fails++; $display("FAIL midrst_no_ack got 0 exp 1"); end
    i_rst = 1'b1;
    #1;
    tests++; if (o_dbus_ack !== 1'b0) begin fails++; $display("FAIL midrst_ack_drop got %b exp 0", o_dbus_ack); end
    i_dbus_cyc = 1'b0; i_dbus_we = 1'b0;
    @(negedge clk);
    i_rst = 1'b0;
    dbus_xfer(32'h10, 32'h0, 4'h0, 1'b0, rdt, lat);
    tests++; if (lat != 1) begin fails++; $display("FAIL midrst_idle_lat got %0d exp 1", lat); end
    tests++; if (rdt !== 32'h55AA_55AA) begin fails++; $display("FAIL midrst_write got %h exp 55aa55aa", rdt); end
  endtask

  initial begin
    tests = 0; fails = 0;
    i_rst = 1'b1;
    i_ibus_adr = '0; i_ibus_cyc = 1'b0;
    i_dbus_adr = '0; i_dbus_dat = '0; i_dbus_sel = '0; i_dbus_we = 1'b0; i_dbus_cyc = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = '0;
    test_reset;
    test_ibus_fetch;
    test_host;
    test_byte_lanes;
    test_arbitration;
    test_out_of_range;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
